// File: rtl/ball_motion.sv
// Ball position engine for the Breakout playfield.
// Serves the ball from the paddle and moves it on a fixed tick. Reflects it off the
// walls, the paddle and brick hits, counts lost lives, and flags the ball's pixel area.
module ball_motion #(
    parameter int BALL_HALF = 4,
    parameter int STEP      = 2,
    parameter int TICK_DIV  = 500000,
    parameter int H_BAR     = 8,
    parameter int W_BAR     = 64,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int LIVES     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       launch,
    input  logic       brick_hit,
    input  logic [9:0] bar_x,
    input  logic [9:0] bar_y,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       area,
    output logic       bar_bounce,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        MISS  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [9:0]  HALF      = 10'(BALL_HALF);
    localparam logic [9:0]  STP       = 10'(STEP);
    localparam logic [9:0]  HBAR      = 10'(H_BAR);
    localparam logic [9:0]  WBAR      = 10'(W_BAR);
    localparam logic [9:0]  RIGHT_LIM = 10'(SCREEN_W - BALL_HALF);
    localparam logic [9:0]  LEFT_LIM  = 10'(BALL_HALF + STEP);
    localparam logic [9:0]  FLOOR_LIM = 10'(SCREEN_H - BALL_HALF);
    localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);

    state_t      st;
    logic [19:0] tick_cnt;
    logic        tick;
    logic        dx_right;
    logic        dy_down;
    logic        pending;

    logic [9:0]  bar_top;
    logic [9:0]  x_mv;
    logic        dx_mv;
    logic [9:0]  y_mv;
    logic        dy_mv;
    logic        bounce_mv;
    logic        miss_mv;
    logic        flip;

    assign tick    = (tick_cnt == TICK_LAST);
    assign bar_top = bar_y - HBAR;
    assign flip    = pending | brick_hit;
    assign state   = st;

    // Free-running move-tick divider
    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 20'd1;
        end
    end

    // Horizontal candidate move with side-wall reflection
    always_comb begin
        x_mv  = x;
        dx_mv = dx_right;
        if (dx_right) begin
            if (x + STP >= RIGHT_LIM) begin
                x_mv  = RIGHT_LIM;
                dx_mv = 1'b0;
            end else begin
                x_mv = x + STP;
            end
        end else begin
            if (x <= LEFT_LIM) begin
                x_mv  = HALF;
                dx_mv = 1'b1;
            end else begin
                x_mv = x - STP;
            end
        end
    end

    // Vertical candidate move: top wall, paddle, floor, brick flip, plain step (priority order)
    always_comb begin
        y_mv      = y;
        dy_mv     = dy_down;
        bounce_mv = 1'b0;
        miss_mv   = 1'b0;
        if (!dy_down && (y <= LEFT_LIM)) begin
            y_mv  = HALF;
            dy_mv = 1'b1;
        end else if (dy_down && (y + HALF <= bar_top) && (y + HALF + STP >= bar_top)
                     && (x + HALF + WBAR >= bar_x) && (x <= bar_x + WBAR + HALF)) begin
            y_mv      = bar_top - HALF;
            dy_mv     = 1'b0;
            bounce_mv = 1'b1;
        end else if (dy_down && (y + STP >= FLOOR_LIM)) begin
            miss_mv = 1'b1;
        end else begin
            dy_mv = flip ? ~dy_down : dy_down;
            y_mv  = dy_mv ? (y + STP) : (y - STP);
        end
    end

    // Game FSM with registered position, direction, lives and status outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            st         <= SERVE;
            x          <= 10'd320;
            y          <= 10'd452;
            dx_right   <= 1'b1;
            dy_down    <= 1'b0;
            lives      <= 2'(LIVES);
            game_over  <= 1'b0;
            bar_bounce <= 1'b0;
            pending    <= 1'b0;
        end else begin
            bar_bounce <= 1'b0;
            case (st)
                SERVE: begin
                    x        <= bar_x;
                    y        <= bar_top - HALF;
                    dx_right <= 1'b1;
                    dy_down  <= 1'b0;
                    pending  <= 1'b0;
                    if (!launch) begin
                        st <= MOVE;
                    end
                end
                MOVE: begin
                    if (tick) begin
                        // a brick hit arriving with a wall/paddle/floor event is dropped
                        pending <= 1'b0;
                        if (miss_mv) begin
                            st <= MISS;
                        end else begin
                            x          <= x_mv;
                            dx_right   <= dx_mv;
                            y          <= y_mv;
                            dy_down    <= dy_mv;
                            bar_bounce <= bounce_mv;
                        end
                    end else if (brick_hit) begin
                        pending <= 1'b1;
                    end
                end
                MISS: begin
                    lives <= lives - 2'd1;
                    if (lives == 2'd1) begin
                        st        <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        st <= SERVE;
                    end
                end
                OVER: begin
                    lives     <= '0;
                    game_over <= 1'b1;
                end
                default: st <= SERVE;
            endcase
        end
    end

    assign area = (next_x + HALF >= x) && (next_x <= x + HALF) &&
                  (next_y + HALF >= y) && (next_y <= y + HALF);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed steps plus randomized play against
// a behavioural model of the game rules.
module tb_ball_motion;

    logic       clock = 1'b0;
    logic       reset;
    logic       launch;
    logic       brick_hit;
    logic [9:0] bar_x;
    logic [9:0] bar_y;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [9:0] x;
    logic [9:0] y;
    logic       area;
    logic       bar_bounce;
    logic [1:0] lives;
    logic       game_over;
    logic [1:0] state;

    ball_motion #(.TICK_DIV(4)) dut (
        .clock(clock), .reset(reset), .launch(launch), .brick_hit(brick_hit),
        .bar_x(bar_x), .bar_y(bar_y), .next_x(next_x), .next_y(next_y),
        .x(x), .y(y), .area(area), .bar_bounce(bar_bounce), .lives(lives),
        .game_over(game_over), .state(state)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // model of the game: position, velocity sign (+1 right/down, -1 left/up), lives, phase
    int mx, my, mvx, mvy, mlives, mst, mcnt, mgo, mbb;
    bit mpend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_clock();
        int  top, nx, nvx, ny, nvy;
        bit  tick, flip, miss;
        if (!reset) begin
            mst = 0; mx = 320; my = 452; mvx = 1; mvy = -1;
            mlives = 3; mgo = 0; mbb = 0; mcnt = 0; mpend = 0;
            return;
        end
        tick = (mcnt == 3);
        mcnt = (mcnt + 1) % 4;
        mbb  = 0;
        top  = int'(bar_y) - 8;
        case (mst)
            0: begin
                mx = bar_x; my = top - 4; mvx = 1; mvy = -1; mpend = 0;
                if (!launch) mst = 1;
            end
            1: begin
                if (tick) begin
                    flip  = mpend || brick_hit;
                    mpend = 0;
                    miss  = 0;
                    nvx = mvx;
                    if (mvx > 0) begin
                        if (mx + 2 >= 636) begin nx = 636; nvx = -1; end
                        else nx = mx + 2;
                    end else begin
                        if (mx <= 6) begin nx = 4; nvx = 1; end
                        else nx = mx - 2;
                    end
                    nvy = mvy; ny = my;
                    if (mvy < 0 && my <= 6) begin
                        ny = 4; nvy = 1;
                    end else if (mvy > 0 && my + 4 <= top && my + 6 >= top &&
                                 mx + 68 >= int'(bar_x) && mx <= int'(bar_x) + 68) begin
                        ny = top - 4; nvy = -1; mbb = 1;
                    end else if (mvy > 0 && my + 2 >= 476) begin
                        miss = 1;
                    end else begin
                        nvy = flip ? -mvy : mvy;
                        ny  = my + 2 * nvy;
                    end
                    if (miss) mst = 2;
                    else begin mx = nx; mvx = nvx; my = ny; mvy = nvy; end
                end else if (brick_hit) begin
                    mpend = 1;
                end
            end
            2: begin
                mlives = mlives - 1;
                if (mlives == 0) begin mst = 3; mgo = 1; end
                else mst = 0;
            end
            default: ;
        endcase
    endtask

    // one clock: update model, clock the DUT, then compare every output
    task automatic step();
        int ma;
        model_clock();
        @(posedge clock);
        #1;
        if ($urandom_range(0, 1) == 0) begin
            next_x = 10'(mx + int'($urandom_range(0, 12)) - 6);
            next_y = 10'(my + int'($urandom_range(0, 12)) - 6);
        end else begin
            next_x = 10'($urandom_range(0, 639));
            next_y = 10'($urandom_range(0, 479));
        end
        #1;
        ma = (int'(next_x) + 4 >= mx && int'(next_x) <= mx + 4 &&
              int'(next_y) + 4 >= my && int'(next_y) <= my + 4) ? 1 : 0;
        chk("x", x, mx);
        chk("y", y, my);
        chk("lives", lives, mlives);
        chk("state", state, mst);
        chk("game_over", game_over, mgo);
        chk("bar_bounce", bar_bounce, mbb);
        chk("area", area, ma);
    endtask

    initial begin
        int y0, off, bx, mode_len, px, py;
        bit moved;

        reset = 1'b0; launch = 1'b1; brick_hit = 1'b0;
        bar_x = 10'd320; bar_y = 10'd464; next_x = '0; next_y = '0;
        mx = 0; my = 0; mvx = 1; mvy = -1; mlives = 0; mst = 0; mcnt = 0;
        mgo = 0; mbb = 0; mpend = 0;

        // reset state
        step(); step();
        chk("rst_x", x, 320);
        chk("rst_y", y, 452);
        chk("rst_lives", lives, 3);
        chk("rst_state", state, 0);
        chk("rst_game_over", game_over, 0);

        // ball follows paddle while serving
        reset = 1'b1; bar_x = 10'd400;
        step();
        chk("serve_follow_x", x, 400);

        // serve
        launch = 1'b0;
        step();
        launch = 1'b1;
        chk("launch_state", state, 1);
        moved = 0;
        for (int i = 0; i < 8 && !moved; i++) begin
            step();
            if (mx != 400) moved = 1;
        end
        chk("first_move_x", x, 402);
        chk("first_move_y", y, 450);
        for (int i = 0; i < 4; i++) step();
        chk("tick_period_x", x, 404);

        // brick hit while rising reverses on the next tick
        y0 = my;
        brick_hit = 1'b1;
        step();
        brick_hit = 1'b0;
        moved = 0;
        for (int i = 0; i < 8 && !moved; i++) begin
            step();
            if (my != y0) moved = 1;
        end
        chk("brick_flip_y", y, y0 + 2);

        // reset wins while moving
        for (int i = 0; i < 10; i++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_move_state", state, 0);
        chk("rst_move_x", x, 320);

        // randomized play: alternate paddle tracking (bounces) with paddle away (misses)
        off = 0;
        mode_len = 4500;
        for (int c = 0; c < 40000 && mst != 3; c++) begin
            launch = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            if ((c % mode_len) < 2000) begin
                brick_hit = ($urandom_range(0, 39) == 0);
                if (c % 16 == 0) off = int'($urandom_range(0, 120)) - 60;
                bx = mx + off;
                if (bx < 4) bx = 4;
                if (bx > 636) bx = 636;
            end else begin
                brick_hit = 1'b0;
                bx = (mx < 320) ? 576 : 64;
            end
            bar_x = 10'(bx);
            step();
        end
        launch = 1'b1; brick_hit = 1'b0;
        chk("over_state", state, 3);
        chk("over_game_over", game_over, 1);
        chk("over_lives", lives, 0);

        // launch and brick hits ignored once over
        px = mx; py = my;
        launch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            brick_hit = ($urandom_range(0, 3) == 0);
            step();
        end
        launch = 1'b1; brick_hit = 1'b0;
        chk("over_hold_state", state, 3);
        chk("over_hold_x", x, px);
        chk("over_hold_y", y, py);

        // reset restores a fresh game
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("restart_lives", lives, 3);
        chk("restart_state", state, 0);
        chk("restart_game_over", game_over, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
